tape_streamer: RTL

TAPE_STREAMER -- requirements
Module: tape_streamer

---
 rtl/tape_pkg.sv | 22 ++
 rtl/tape_bit_encoder.sv | 88 ++++++++
 rtl/tape_streamer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tape_pkg.sv
// Shared types and constants for the tape streamer.
//   POS_W      : width of byte positions / lengths
//   HALF0_DEF  : default half-period (cycles) of a 0 bit
//   HALF1_DEF  : default half-period (cycles) of a 1 bit
//   DECAY_DEF  : default cycles per level-meter decay step
//   state_e    : streamer control states
package tape_pkg;

  localparam int unsigned POS_W     = 25;
  localparam int unsigned HALF0_DEF = 16;
  localparam int unsigned HALF1_DEF = 8;
  localparam int unsigned DECAY_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/tape_bit_encoder.sv
// Encodes one bit as a high half-period followed by a low half-period.
//   i_clk, reset : clock, synchronous active-high reset
//   abort        : drop the bit in progress and go quiet
//   start        : begin a bit (valid when idle or in the bit_done cycle)
//   bit_val      : value of the bit being started
//   cas_out      : encoded waveform
//   bit_done     : high during the last cycle of a bit
module tape_bit_encoder
  import tape_pkg::*;
#(
  parameter int unsigned HALF0 = HALF0_DEF,
  parameter int unsigned HALF1 = HALF1_DEF
) (
  input  logic i_clk,
  input  logic reset,
  input  logic abort,
  input  logic start,
  input  logic bit_val,
  output logic cas_out,
  output logic bit_done
);

  localparam int unsigned HMAX  = (HALF0 > HALF1) ? HALF0 : HALF1;
  localparam int unsigned CNT_W = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam logic [CNT_W-1:0] H0_M1 = CNT_W'(HALF0 - 1);
  localparam logic [CNT_W-1:0] H1_M1 = CNT_W'(HALF1 - 1);

  logic             busy, busy_n;
  logic             low_ph, low_n;
  logic             bit_q, bit_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             cas_n, done_n;

  // Phase sequencing; bit_done is registered by looking one cycle ahead.
  always_comb begin
    busy_n = busy;
    low_n  = low_ph;
    bit_n  = bit_q;
    cnt_n  = cnt;
    cas_n  = cas_out;
    if (abort) begin
      busy_n = 1'b0;
      low_n  = 1'b0;
      cnt_n  = '0;
      cas_n  = 1'b0;
    end else if (start) begin
      busy_n = 1'b1;
      low_n  = 1'b0;
      bit_n  = bit_val;
      cnt_n  = bit_val ? H1_M1 : H0_M1;
      cas_n  = 1'b1;
    end else if (busy) begin
      if (cnt == '0) begin
        if (!low_ph) begin
          low_n = 1'b1;
          cnt_n = bit_q ? H1_M1 : H0_M1;
          cas_n = 1'b0;
        end else begin
          busy_n = 1'b0;
          low_n  = 1'b0;
          cas_n  = 1'b0;
        end
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end
    done_n = busy_n && low_n && (cnt_n == '0);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      busy     <= 1'b0;
      low_ph   <= 1'b0;
      bit_q    <= 1'b0;
      cnt      <= '0;
      cas_out  <= 1'b0;
      bit_done <= 1'b0;
    end else begin
      busy     <= busy_n;
      low_ph   <= low_n;
      bit_q    <= bit_n;
      cnt      <= cnt_n;
      cas_out  <= cas_n;
      bit_done <= done_n;
    end
  end

endmodule

// File: rtl/tape_streamer.sv
// Streams a byte file from memory as a cassette waveform, MSB first.
//   i_clk, reset        : clock, synchronous active-high reset
//   play                : level, 1 = run, 0 = pause
//   rewind              : pulse, return to byte 0 and idle
//   len                 : file length, latched at play start
//   mem_rd/mem_addr     : byte read request (held until mem_ack)
//   mem_ack/mem_data    : read completion and data
//   cas_out             : encoded waveform
//   pos, max            : bytes sent, latched length
//   tape_data           : peak-hold level meter
//   done                : stream finished
module tape_streamer
  import tape_pkg::*;
#(
  parameter int unsigned HALF0 = HALF0_DEF,
  parameter int unsigned HALF1 = HALF1_DEF,
  parameter int unsigned DECAY = DECAY_DEF
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             play,
  input  logic             rewind,
  input  logic [POS_W-1:0] len,
  output logic             mem_rd,
  output logic [POS_W-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [7:0]       mem_data,
  output logic             cas_out,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] max,
  output logic [7:0]       tape_data,
  output logic             done
);

  localparam int unsigned DCNT_W = (DECAY > 1) ? $clog2(DECAY) : 1;
  localparam logic [DCNT_W-1:0] DLAST = DCNT_W'(DECAY - 1);

  state_e state, state_n;

  logic [POS_W-1:0]  pos_n, max_n, addr_n, pos_inc;
  logic              rd_n, done_n;
  logic [7:0]        byte_q, byte_n;
  logic [2:0]        bit_idx, idx_n;
  logic              in_bit, inbit_n;
  logic              start_c, bit_c, bit_done, ack_ok;
  logic [7:0]        tape_n;
  logic [DCNT_W-1:0] dcnt, dcnt_n;
  logic              step_c, load_c;

  assign pos_inc = pos + POS_W'(1);
  // Ack only counts while a request is actually outstanding.
  assign ack_ok  = (state == ST_FETCH) && mem_rd && mem_ack;

  // State register
  always_ff @(posedge i_clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next-state logic; rewind overrides everything.
  always_comb begin
    state_n = state;
    if (rewind) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (play) state_n = (len == '0) ? ST_DONE : ST_FETCH;
        ST_FETCH: if (ack_ok) state_n = play ? ST_SEND : ST_PAUSE;
        ST_SEND: begin
          if (bit_done) begin
            if (bit_idx == 3'd0) state_n = (pos_inc == max) ? ST_DONE : ST_FETCH;
            else if (!play)      state_n = ST_PAUSE;
          end else if (!in_bit && !play) begin
            state_n = ST_PAUSE;
          end
        end
        ST_PAUSE: if (play) state_n = ST_SEND;
        ST_DONE:  state_n = ST_DONE;
        default:  state_n = ST_IDLE;
      endcase
    end
  end

  // Output / datapath next values; a new bit may start in the bit_done cycle.
  always_comb begin
    start_c = 1'b0;
    pos_n   = pos;
    max_n   = max;
    rd_n    = mem_rd;
    addr_n  = mem_addr;
    done_n  = done;
    byte_n  = byte_q;
    idx_n   = bit_idx;
    inbit_n = in_bit;
    if (rewind) begin
      pos_n   = '0;
      rd_n    = 1'b0;
      addr_n  = '0;
      done_n  = 1'b0;
      idx_n   = 3'd7;
      inbit_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (play) begin
            max_n = len;
            if (len == '0) begin
              done_n = 1'b1;
            end else begin
              rd_n   = 1'b1;
              addr_n = pos;
            end
          end
        end
        ST_FETCH: begin
          if (ack_ok) begin
            byte_n  = mem_data;
            rd_n    = 1'b0;
            idx_n   = 3'd7;
            inbit_n = 1'b0;
          end
        end
        ST_SEND: begin
          if (bit_done) begin
            if (bit_idx == 3'd0) begin
              inbit_n = 1'b0;
              if (pos != max) pos_n = pos_inc;
              if (pos_inc == max) begin
                done_n = 1'b1;
              end else begin
                rd_n   = 1'b1;
                addr_n = pos_inc;
              end
            end else begin
              idx_n   = bit_idx - 3'd1;
              start_c = play;
              inbit_n = play;
            end
          end else if (!in_bit && play) begin
            start_c = 1'b1;
            inbit_n = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (play) begin
            start_c = 1'b1;
            inbit_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
    bit_c = byte_q[idx_n];
  end

  // Peak-hold meter: a louder captured byte wins over a decay step.
  always_comb begin
    step_c = (dcnt == DLAST);
    dcnt_n = step_c ? '0 : dcnt + DCNT_W'(1);
    load_c = ack_ok && !rewind && (mem_data > tape_data);
    tape_n = tape_data;
    if (load_c)                         tape_n = mem_data;
    else if (step_c && tape_data != '0) tape_n = tape_data - 8'd1;
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      pos       <= '0;
      max       <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
      byte_q    <= '0;
      bit_idx   <= 3'd7;
      in_bit    <= 1'b0;
      tape_data <= '0;
      dcnt      <= '0;
    end else begin
      pos       <= pos_n;
      max       <= max_n;
      mem_rd    <= rd_n;
      mem_addr  <= addr_n;
      done      <= done_n;
      byte_q    <= byte_n;
      bit_idx   <= idx_n;
      in_bit    <= inbit_n;
      tape_data <= tape_n;
      dcnt      <= dcnt_n;
    end
  end

  tape_bit_encoder #(
    .HALF0 (HALF0),
    .HALF1 (HALF1)
  ) u_enc (
    .i_clk    (i_clk),
    .reset    (reset),
    .abort    (rewind),
    .start    (start_c),
    .bit_val  (bit_c),
    .cas_out  (cas_out),
    .bit_done (bit_done)
  );

endmodule
